// File: rtl/irq_enc32t5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_enc32t5_pkg
// Description : Shared widths, FSM state encoding and a one-hot helper for
//               the 32-line interrupt encoder.
// Contents    : IRQ_N   number of request lines
//               IRQ_W   width of the encoded line index
//               state_t presentation FSM state (IDLE / BUSY)
//               onehot  index -> one-hot line vector
// Revision    : 1.0  initial release
// ============================================================================
package irq_enc32t5_pkg;

  localparam int IRQ_N = 32;
  localparam int IRQ_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [IRQ_N-1:0] onehot(input logic [IRQ_W-1:0] idx);
    logic [IRQ_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_enc32t5_pri_enc32.sv
`default_nettype none
// ============================================================================
// Module      : irq_enc32t5_pri_enc32
// Description : Combinational 32-to-5 priority encoder, lowest index wins.
// Ports       : eligible  in  [31:0] candidate lines
//               code      out [4:0]  index of the lowest set bit (0 if none)
//               any       out        at least one eligible line
// Revision    : 1.0  initial release
// ============================================================================
module irq_enc32t5_pri_enc32
  import irq_enc32t5_pkg::*;
(
  input  logic [IRQ_N-1:0] eligible,
  output logic [IRQ_W-1:0] code,
  output logic             any
);

  // Scanning from the top down lets the lowest set index overwrite last.
  always_comb begin
    code = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        code = IRQ_W'(i);
      end
    end
  end

  assign any = |eligible;

endmodule
`default_nettype wire

// File: rtl/irq_enc32t5.sv
`default_nettype none
// ============================================================================
// Module      : irq_enc32t5
// Description : 32-line interrupt collector with writable mask and a
//               registered priority code presented over a VLD/ACK handshake.
// Parameters  : EDGE      1 = capture REQ rising edges, 0 = capture REQ level
//               MASK_RST  reset value of the mask register (1 = masked)
// Ports       : clk      in         system clock
//               rst_n    in         asynchronous active-low reset
//               en       in         allows a new code to be presented
//               req      in  [31:0] request lines
//               mask_we  in         mask write strobe
//               mask_d   in  [31:0] mask write data
//               ack      in         CPU acknowledge of the presented code
//               vld      out        code valid, awaiting ack
//               code     out [4:0]  serviced line index
//               pend     out [31:0] pending register
//               mask     out [31:0] mask register
// Revision    : 1.0  initial release
// ============================================================================
module irq_enc32t5
  import irq_enc32t5_pkg::*;
#(
  parameter bit               EDGE     = 1'b1,
  parameter logic [IRQ_N-1:0] MASK_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IRQ_N-1:0] req,
  input  logic             mask_we,
  input  logic [IRQ_N-1:0] mask_d,
  input  logic             ack,
  output logic             vld,
  output logic [IRQ_W-1:0] code,
  output logic [IRQ_N-1:0] pend,
  output logic [IRQ_N-1:0] mask
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IRQ_W-1:0] r_code;
  logic [IRQ_W-1:0] w_code_nxt;
  logic [IRQ_N-1:0] r_pend;
  logic [IRQ_N-1:0] r_mask;
  logic [IRQ_N-1:0] r_req_d;
  logic [IRQ_N-1:0] w_new;
  logic [IRQ_N-1:0] w_clr;
  logic [IRQ_N-1:0] w_eligible;
  logic [IRQ_W-1:0] w_enc_code;
  logic             w_enc_any;

  assign w_new      = EDGE ? (req & ~r_req_d) : req;
  assign w_eligible = r_pend & ~r_mask;

  irq_enc32t5_pri_enc32 u_pri_enc (
    .eligible (w_eligible),
    .code     (w_enc_code),
    .any      (w_enc_any)
  );

  // The code is latched on entry to BUSY and never re-evaluated there, so a
  // higher-priority arrival or a mask/en change cannot preempt it.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_clr       = '0;
    case (r_state)
      IDLE: begin
        if (en && w_enc_any) begin
          w_state_nxt = BUSY;
          w_code_nxt  = w_enc_code;
        end
      end
      BUSY: begin
        if (ack) begin
          w_clr       = onehot(r_code);
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_pend  <= '0;
      r_mask  <= MASK_RST;
      r_req_d <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      // New captures are OR-ed in after the clear so set wins on a collision.
      r_pend  <= (r_pend & ~w_clr) | w_new;
      r_req_d <= req;
      if (mask_we) begin
        r_mask <= mask_d;
      end
    end
  end

  assign vld  = (r_state == BUSY);
  assign code = r_code;
  assign pend = r_pend;
  assign mask = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_irq_enc32t5.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_enc32t5
// Description : Randomized and directed bench for irq_enc32t5 with a
//               behavioural reference model and a code scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_irq_enc32t5;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] req;
  logic        mask_we;
  logic [31:0] mask_d;
  logic        ack;
  logic        vld;
  logic [4:0]  code;
  logic [31:0] pend;
  logic [31:0] mask;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state
  logic        m_busy     = 1'b0;
  logic [4:0]  m_code     = '0;
  logic [31:0] m_pend     = '0;
  logic [31:0] m_mask     = '0;
  logic [31:0] m_req_prev = '0;
  logic [31:0] m_new;
  logic [31:0] m_clr;
  logic [31:0] m_elig;
  logic        prev_vld   = 1'b0;
  logic [4:0]  exp_q[$];
  logic [4:0]  exp_code;

  irq_enc32t5 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .mask_we (mask_we),
    .mask_d  (mask_d),
    .ack     (ack),
    .vld     (vld),
    .code    (code),
    .pend    (pend),
    .mask    (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Index of the lowest set bit: isolate it arithmetically, then take log2.
  function automatic logic [4:0] lowest(input logic [31:0] x);
    logic [31:0] iso;
    iso = x & (~x + 32'd1);
    return 5'($clog2(iso));
  endfunction

  // Reference model, one step per rising edge, checked just after the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy     = 1'b0;
      m_code     = '0;
      m_pend     = '0;
      m_mask     = '0;
      m_req_prev = '0;
      exp_q.delete();
    end else begin
      m_new  = req & ~m_req_prev;
      m_clr  = (m_busy && ack) ? (32'd1 << m_code) : 32'd0;
      m_elig = m_pend & ~m_mask;
      if (!m_busy) begin
        if (en && m_elig != 32'd0) begin
          m_busy = 1'b1;
          m_code = lowest(m_elig);
          exp_q.push_back(m_code);
        end
      end else if (ack) begin
        m_busy = 1'b0;
      end
      m_pend = (m_pend & ~m_clr) | m_new;
      if (mask_we) m_mask = mask_d;
      m_req_prev = req;
      #1;
      chk("vld", {31'd0, vld}, {31'd0, m_busy});
      chk("code", {27'd0, code}, {27'd0, m_code});
      chk("pend", pend, m_pend);
      chk("mask", mask, m_mask);
    end
  end

  // Scoreboard monitor: every new presentation pops one expected code.
  always @(negedge clk) begin
    if (rst_n && vld && !prev_vld) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got code %0d expected no presentation at %0t", code, $time);
      end else begin
        exp_code = exp_q.pop_front();
        chk("sb_code", {27'd0, code}, {27'd0, exp_code});
      end
    end
    prev_vld = vld;
  end

  task automatic wait_vld(input string nm);
    int n;
    n = 0;
    while (!vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!vld) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got vld=0 expected vld=1 within 20 cycles", nm);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic pulse_req(input logic [31:0] v);
    req = v;
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    rst_n   = 1'b1;
    en      = 1'b1;
    req     = '0;
    mask_we = 1'b0;
    mask_d  = '0;
    ack     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_code", {27'd0, code}, 32'd0);
    chk("rst_pend", pend, 32'd0);
    chk("rst_mask", mask, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // priority
    pulse_req(32'h8000_0010);
    chk("prio_pend", pend, 32'h8000_0010);
    wait_vld("prio_first");
    chk("prio_code4", {27'd0, code}, 32'd4);
    do_ack();
    chk("prio_pend_after_ack", pend, 32'h8000_0000);
    chk("prio_gap", {31'd0, vld}, 32'd0);
    wait_vld("prio_second");
    chk("prio_code31", {27'd0, code}, 32'd31);
    do_ack();
    chk("prio_pend_empty", pend, 32'd0);
    @(negedge clk);

    // mask
    mask_we = 1'b1;
    mask_d  = 32'h0000_0010;
    @(negedge clk);
    mask_we = 1'b0;
    pulse_req(32'h0000_0210);
    wait_vld("mask_first");
    chk("mask_code9", {27'd0, code}, 32'd9);
    do_ack();
    mask_we = 1'b1;
    mask_d  = '0;
    @(negedge clk);
    mask_we = 1'b0;
    wait_vld("mask_second");
    chk("mask_code4", {27'd0, code}, 32'd4);
    do_ack();
    @(negedge clk);

    // set and clear on the same edge
    pulse_req(32'h0000_0008);
    wait_vld("setclr_first");
    chk("setclr_code3", {27'd0, code}, 32'd3);
    ack = 1'b1;
    req = 32'h0000_0008;
    @(negedge clk);
    ack = 1'b0;
    req = '0;
    chk("setclr_vld_low", {31'd0, vld}, 32'd0);
    chk("setclr_pend3", {31'd0, pend[3]}, 32'd1);
    wait_vld("setclr_again");
    chk("setclr_code3_again", {27'd0, code}, 32'd3);
    do_ack();
    @(negedge clk);

    // no preemption
    pulse_req(32'h0000_0080);
    wait_vld("preempt_first");
    pulse_req(32'h0000_0001);
    @(negedge clk);
    chk("preempt_hold_vld", {31'd0, vld}, 32'd1);
    chk("preempt_hold_code", {27'd0, code}, 32'd7);
    do_ack();
    wait_vld("preempt_second");
    chk("preempt_code0", {27'd0, code}, 32'd0);
    do_ack();
    @(negedge clk);

    // en gating
    en = 1'b0;
    pulse_req(32'h0000_0100);
    pulse_req(32'h0000_0200);
    @(negedge clk);
    chk("en_blocked_vld", {31'd0, vld}, 32'd0);
    chk("en_accum_pend", pend, 32'h0000_0300);
    en = 1'b1;
    @(negedge clk);
    chk("en_vld", {31'd0, vld}, 32'd1);
    chk("en_code8", {27'd0, code}, 32'd8);
    do_ack();
    wait_vld("en_second");
    chk("en_code9", {27'd0, code}, 32'd9);
    do_ack();
    @(negedge clk);

    // asynchronous reset while busy
    pulse_req(32'h0010_1000);
    wait_vld("arst_busy");
    chk("arst_code12", {27'd0, code}, 32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, vld}, 32'd0);
    chk("arst_pend", pend, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_quiet", {31'd0, vld}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req     = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'd0;
      en      = ($urandom_range(0, 7) != 0);
      ack     = ($urandom_range(0, 2) == 0);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_d  = $urandom & $urandom;
      @(negedge clk);
    end
    req     = '0;
    ack     = 1'b0;
    mask_we = 1'b0;
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_enc32t5.md
Name: irq_enc32t5

Overview:
- 32-line interrupt request collector and registered priority encoder.
- Inverse of the 5-to-32 decoder used for select generation: folds 32 request lines into one 5-bit code and presents it to the CPU control unit over a VLD/ACK handshake.
- Holds pending requests, applies a writable mask, and clears the serviced line on acknowledge.
- Sits between peripheral request lines and the CPU interrupt/exception logic.

Parameters:
- EDGE, 1, 1 = a request is registered on the REQ rising edge; 0 = REQ level sets pending every cycle it is high.
- MASK_RST, 32'h0000_0000, reset value of the mask register (1 = line masked).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- En  input  1  presentation enable; pending capture continues when low.
- REQ  input  32  request lines; bit i maps to code i.
- MASK_WE  input  1  mask write strobe.
- MASK_D  input  32  mask write data.
- ACK  input  1  CPU acknowledge of the presented code.
- VLD  output  1  CODE is valid and awaiting ACK.
- CODE  output  5  encoded index of the serviced line.
- PEND  output  32  pending register, for debug and status reads.
- MASK  output  32  current mask register.

Behaviour:
- Reset (async, RST_N=0):
  - VLD=0, CODE=0, PEND=0, MASK=MASK_RST.
  - Edge-detect history register = 0.
  - FSM goes to IDLE.
- Request capture, every cycle:
  - new = EDGE ? (REQ & ~req_d) : REQ; req_d <= REQ.
  - PEND <= (PEND & ~clr) | new.
  - Set wins over clear on the same bit in the same cycle: the line stays pending.
- Masking:
  - eligible = PEND & ~MASK.
  - MASK_WE=1 loads MASK_D at the edge; the new mask takes effect for selection on the next cycle.
  - Masked lines still accumulate in PEND.
- Priority: lowest index wins (bit 0 highest). Code = index of the lowest set bit of eligible.
- FSM state IDLE (VLD=0):
  - If En=1 and eligible != 0: CODE <= priority code, VLD <= 1, go to BUSY.
  - Otherwise stay in IDLE. CODE holds its last value.
- FSM state BUSY (VLD=1):
  - CODE is stable and cannot be preempted, even by a higher-priority arrival or by masking or disabling that line.
  - When ACK=1: clr = one-hot(CODE), VLD <= 0, go to IDLE.
- Spacing: after each ACK the FSM spends at least one cycle in IDLE, so back-to-back codes are separated by one VLD-low cycle.
- ACK while in IDLE is ignored.
- En=0:
  - Blocks IDLE->BUSY only.
  - In BUSY, VLD stays high until ACK.
- Latency:
  - REQ rises before edge k: PEND[i]=1 after edge k, VLD=1 after edge k+1, provided the FSM is IDLE with En=1.
  - ACK sampled at edge m: VLD=0 and PEND bit cleared after edge m.
- EDGE=0 with REQ still high at ACK: the bit re-sets the next cycle and is serviced again. Requestors must drop REQ before ACK.
- Reset mid-BUSY: the outstanding code is abandoned and all pending state is lost.
- Widths: CODE is exactly 5 bits. No overflow is possible.

Decomposition:
- Shared package constants: IRQ_N=32, IRQ_W=5, FSM state encodings IDLE=1'b0, BUSY=1'b1.
- One natural sub-module, pri_enc32: purely combinational, 32-bit eligible vector in, 5-bit code plus any flag out, lowest index first.
- The top level holds all registers and the FSM.

Test Plan:
- Reset with MASK_RST=0: REQ=0 -> VLD=0, CODE=0, PEND=0, MASK=0 immediately on RST_N low, before any CLK edge.
- Priority:
  - REQ=32'h8000_0010 pulsed for 1 cycle -> PEND=32'h8000_0010, then VLD=1 with CODE=4.
  - ACK -> PEND=32'h8000_0000, one VLD-low cycle, then CODE=31.
  - ACK -> PEND=0.
- Mask: write MASK=32'h0000_0010 with REQ bits 4 and 9 -> CODE=9. Clear the mask after ACK -> CODE=4.
- Same-cycle set/clear: CODE=3 presented, ACK in the same cycle as a new REQ[3] rising edge -> VLD drops, PEND[3] stays 1, CODE=3 is presented again after one idle cycle.
- No preemption, En gating:
  - BUSY with CODE=7, REQ[0] rises -> CODE stays 7 until ACK, then 0 is presented.
  - En=0 with PEND!=0 -> VLD stays 0 and PEND keeps accumulating. Raising En gives VLD=1 one edge later.
- Async reset mid-BUSY (CODE=12): RST_N low between edges -> VLD=0 and PEND=0 at once. After release, nothing is presented until a new REQ edge.
